// File: rtl/pc_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit_if
// Brief    : Next-PC, instruction-memory and decode-side signals of the
//            PC fetch unit, bundled with master (fetch unit) and slave
//            (surrounding core) views.
// Revision : 1.0 - initial release
// ============================================================================
interface pc_fetch_unit_if;
    logic [31:0] npc_in;
    logic        npc_valid;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst_out;
    logic        inst_valid;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_out;
    logic        fetch_err;
    logic [31:0] icount;

    modport master (
        input  npc_in, npc_valid, imem_ack, imem_rdata,
        output imem_req, imem_addr, inst_out, inst_valid,
               pc_out, pc_plus4_out, fetch_err, icount
    );

    modport slave (
        output npc_in, npc_valid, imem_ack, imem_rdata,
        input  imem_req, imem_addr, inst_out, inst_valid,
               pc_out, pc_plus4_out, fetch_err, icount
    );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Brief    : Holds the PC, fetches the instruction at PC over req/ack, and
//            presents it to decode until the core commits the next PC.
//            Optional macro FETCH_ICOUNT_EN adds a committed-instruction count.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic          clk,
    input  wire logic          rst,
    pc_fetch_unit_if.master    bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        inst_valid_q, inst_valid_d;
    logic        fetch_err_q, fetch_err_d;
    logic        commit;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= 32'h0;
            inst_valid_q <= 1'b0;
            fetch_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            fetch_err_q  <= fetch_err_d;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
        fetch_err_d  = fetch_err_q;
        commit       = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (bus.imem_ack) begin
                    inst_d       = bus.imem_rdata;
                    inst_valid_d = 1'b1;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                if (bus.npc_valid) begin
                    // Misaligned target is still latched so debug can see it
                    commit       = 1'b1;
                    pc_d         = bus.npc_in;
                    inst_valid_d = 1'b0;
                    if (bus.npc_in[1:0] != 2'b00) begin
                        fetch_err_d = 1'b1;
                        state_d     = S_HALT;
                    end else begin
                        state_d     = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
        endcase
    end

    // Outputs
    always_comb begin
        bus.imem_req = (state_q == S_FETCH);
    end

    assign bus.imem_addr    = pc_q;
    assign bus.pc_out       = pc_q;
    assign bus.pc_plus4_out = pc_q + 32'd4;
    assign bus.inst_out     = inst_q;
    assign bus.inst_valid   = inst_valid_q;
    assign bus.fetch_err    = fetch_err_q;

`ifdef FETCH_ICOUNT_EN
    logic [31:0] icount_q, icount_d;

    always_comb begin
        icount_d = commit ? (icount_q + 32'd1) : icount_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            icount_q <= 32'h0;
        end else begin
            icount_q <= icount_d;
        end
    end

    assign bus.icount = icount_q;
`else
    assign bus.icount = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_unit
// Brief    : Directed plus randomized stimulus for pc_fetch_unit, checked
//            each cycle against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

    localparam logic [31:0] C_RESET_PC = 32'h0000_3000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_fetch_unit_if bus ();

    pc_fetch_unit #(
        .RESET_PC (C_RESET_PC)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: the PC, whether an instruction is held for decode,
    // whether the unit has left its post-reset idle cycle, and the error flag.
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic        m_have_inst;
    logic        m_started;
    logic        m_err;
    logic [31:0] m_count;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        if (rst) begin
            m_pc        = C_RESET_PC;
            m_inst      = 32'h0;
            m_have_inst = 1'b0;
            m_started   = 1'b0;
            m_err       = 1'b0;
            m_count     = 32'h0;
        end else if (!m_started) begin
            m_started = 1'b1;
        end else if (m_err) begin
            // halted until reset
        end else if (!m_have_inst) begin
            if (bus.imem_ack) begin
                m_inst      = bus.imem_rdata;
                m_have_inst = 1'b1;
            end
        end else if (bus.npc_valid) begin
            m_pc        = bus.npc_in;
            m_have_inst = 1'b0;
            m_count     = m_count + 32'd1;
            if (bus.npc_in[1:0] != 2'b00) m_err = 1'b1;
        end
    endtask

    task automatic check_all();
        logic        exp_req;
        logic [31:0] exp_cnt;
        exp_req = m_started && !m_have_inst && !m_err;
`ifdef FETCH_ICOUNT_EN
        exp_cnt = m_count;
`else
        exp_cnt = 32'h0;
`endif
        check_val("imem_req",     {31'h0, bus.imem_req},   {31'h0, exp_req});
        check_val("imem_addr",    bus.imem_addr,           m_pc);
        check_val("pc_out",       bus.pc_out,              m_pc);
        check_val("pc_plus4_out", bus.pc_plus4_out,        m_pc + 32'd4);
        check_val("inst_valid",   {31'h0, bus.inst_valid}, {31'h0, m_have_inst});
        check_val("inst_out",     bus.inst_out,            m_inst);
        check_val("fetch_err",    {31'h0, bus.fetch_err},  {31'h0, m_err});
        check_val("icount",       bus.icount,              exp_cnt);
    endtask

    // One clock: apply inputs, update model at the edge, check 1 ns later.
    task automatic step(input logic i_rst, input logic i_nv, input logic [31:0] i_npc,
                        input logic i_ack, input logic [31:0] i_rdata);
        rst            = i_rst;
        bus.npc_valid  = i_nv;
        bus.npc_in     = i_npc;
        bus.imem_ack   = i_ack;
        bus.imem_rdata = i_rdata;
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    initial begin
        logic [31:0] npc;
        logic        r;
        int          sel;
        bus.npc_valid  = 1'b0;
        bus.npc_in     = 32'h0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;

        // Reset, then one idle cycle, then fetch at RESET_PC
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h0000_0040, 1'b1, 32'hDEAD_BEEF);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        // Ack in the same cycle as req
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h2008_0005);
        // Commit aligned next PC
        step(1'b0, 1'b1, 32'h0000_3010, 1'b0, 32'h0);
        // Ack delayed three cycles, with a stray commit attempt while fetching
        step(1'b0, 1'b1, 32'h0000_5000, 1'b0, 32'h1111_1111);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h2222_2222);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h3333_3333);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0C00_0ABC);
        // Hold in EXEC, then self-loop commit
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h4444_4444);
        step(1'b0, 1'b1, 32'h0000_3010, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0013);
        // Top-of-memory PC: pc_plus4 wraps to zero
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0077);
        step(1'b0, 1'b1, 32'h0000_3000, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'hAAAA_5555);
        // Misaligned commit halts; inputs afterwards are ignored
        step(1'b0, 1'b1, 32'h0000_3012, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 32'h0000_4000, 1'b1, 32'h5555_AAAA);
        end
        // Reset clears the error; then reset mid-fetch with a stray ack
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h9999_9999);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            r   = ($urandom_range(0, 63) == 0) || (m_err && ($urandom_range(0, 7) == 0));
            sel = $urandom_range(0, 9);
            npc = $urandom;
            if (sel == 0)      npc = m_pc;
            else if (sel == 1) npc = 32'hFFFF_FFFC;
            else if (sel == 2) npc[1:0] = 2'($urandom_range(1, 3));
            else               npc[1:0] = 2'b00;
            step(r, 1'($urandom_range(0, 1)), npc, 1'($urandom_range(0, 1)), $urandom);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
